fifo_rr_write_ctrl: RTL

//  Pointer/flag controller and round-robin write arbiter for the single-clock FIFO memory array.

---
 rtl/fifo_rr_write_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fifo_rr_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module : fifo_rr_write_ctrl
// Brief  : Pointer/flag controller with a round-robin write arbiter for a
//          single-clock first-word-fall-through FIFO memory array.
// Rev    : 1.0 - initial release
// ============================================================================
module fifo_rr_write_ctrl #(
   parameter int WIDTH     = 8,
   parameter int PTR_WIDTH = 5,
   parameter int DEPTH     = 16,
   parameter int NREQ      = 4,
   parameter int AF_LEVEL  = 12
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [NREQ-1:0]         req_in,
   input  logic [NREQ*WIDTH-1:0]   data_in,
   output logic [NREQ-1:0]         grant_out,
   input  logic                    read_in,
   output logic                    empty_out,
   output logic                    full_out,
   output logic                    almost_full_out,
   output logic [PTR_WIDTH-1:0]    count_out,
   output logic                    underflow_out,
   output logic                    mem_write_out,
   output logic [PTR_WIDTH-1:0]    mem_write_ptr_out,
   output logic [PTR_WIDTH-1:0]    mem_read_ptr_out,
   output logic [WIDTH-1:0]        mem_data_out
);

   localparam int                   IDX_W      = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [PTR_WIDTH-1:0] C_DEPTH    = PTR_WIDTH'(DEPTH);
   localparam logic [PTR_WIDTH-1:0] C_AF_LEVEL = PTR_WIDTH'(AF_LEVEL);
   localparam logic [IDX_W-1:0]     C_LAST_RST = IDX_W'(NREQ - 1);
   localparam logic [IDX_W:0]       C_NREQ_EXT = (IDX_W+1)'(NREQ);

   logic [PTR_WIDTH-1:0] r_wptr;
   logic [PTR_WIDTH-1:0] r_rptr;
   logic                 r_underflow;
   logic [IDX_W-1:0]     r_last_q;

   logic [PTR_WIDTH-1:0] w_count;
   logic                 w_empty;
   logic                 w_full;
   logic [NREQ-1:0]      w_grant;
   logic [IDX_W-1:0]     w_grant_idx;
   logic                 w_found;
   logic [IDX_W:0]       w_sum;
   logic [IDX_W-1:0]     w_cand;
   logic                 w_write;
   logic [WIDTH-1:0]     w_data;

   // With DEPTH == 2**(PTR_WIDTH-1), count == DEPTH is exactly "MSBs differ, low bits equal".
   assign w_count = r_wptr - r_rptr;
   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (w_count == C_DEPTH);

   // Search starts one past the last winner; grants are suppressed in reset and when full.
   always_comb begin
      w_grant     = '0;
      w_grant_idx = '0;
      w_found     = 1'b0;
      w_sum       = '0;
      w_cand      = '0;
      if (rstn && !w_full) begin
         for (int k = 1; k <= NREQ; k++) begin
            w_sum = {1'b0, r_last_q} + (IDX_W+1)'(k);
            if (w_sum >= C_NREQ_EXT) begin
               w_sum = w_sum - C_NREQ_EXT;
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!w_found && req_in[w_cand]) begin
               w_grant[w_cand] = 1'b1;
               w_grant_idx     = w_cand;
               w_found         = 1'b1;
            end
         end
      end
   end

   assign w_write = |w_grant;

   always_comb begin
      w_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant[i]) begin
            w_data = w_data | data_in[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_underflow <= 1'b0;
         r_last_q    <= C_LAST_RST;
      end else begin
         if (w_write) begin
            r_wptr   <= r_wptr + PTR_WIDTH'(1);
            r_last_q <= w_grant_idx;
         end
         if (read_in) begin
            if (w_empty) begin
               r_underflow <= 1'b1;
            end else begin
               r_rptr <= r_rptr + PTR_WIDTH'(1);
            end
         end
      end
   end

   assign grant_out         = w_grant;
   assign mem_write_out     = w_write;
   assign mem_data_out      = w_data;
   assign mem_write_ptr_out = r_wptr;
   assign mem_read_ptr_out  = r_rptr;
   assign empty_out         = w_empty;
   assign full_out          = w_full;
   assign count_out         = w_count;
   assign almost_full_out   = (w_count >= C_AF_LEVEL);
   assign underflow_out     = r_underflow;

endmodule
`default_nettype wire
